fadd_pipe: RTL and testbench



---
 rtl/fadd_pipe.sv | 208 ++++++++++++++++++++
 tb/tb_fadd_pipe.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fadd_pipe.sv
// rtl/fadd_pipe.sv - two-stage pipelined floating-point add/subtract with valid/ready flow control
// Optional macro FADD_FTZ_EN: flush subnormal inputs and subnormal results to signed zero.
module fadd_pipe #(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [EW+MW:0] x1,
    input  logic [EW+MW:0] x2,
    input  logic           sub,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [EW+MW:0] y,
    output logic           ovf,
    output logic           inv
);
    localparam int W  = 1 + EW + MW;
    localparam int SW = MW + 5;            // carry, hidden, mantissa, guard, round, sticky
    localparam int LW = $clog2(SW + 1);
    localparam int XW = EW + 2;
`ifdef FADD_FTZ_EN
    localparam bit FTZ = 1'b1;
`else
    localparam bit FTZ = 1'b0;
`endif

    logic          v1_q, v1_d, v2_q, v2_d;
    logic [SW-1:0] sum1_q, sum1_d;
    logic [EW-1:0] exp1_q, exp1_d;
    logic          sgn1_q, sgn1_d;
    logic [LW-1:0] lz1_q, lz1_d;
    logic          spc1_q, spc1_d;
    logic [W-1:0]  spy1_q, spy1_d;
    logic          inv1_q, inv1_d;
    logic [W-1:0]  y_q, y_d;
    logic          ovf_q, ovf_d, inv_q, inv_d;
    logic          s1_ld, s2_ld;

    // Stage 1 combinational: unpack, special cases, align, add
    logic            s_a, s_b, s_big, a_big;
    logic [EW-1:0]   e_a, e_b, ex_a, ex_b, ex_big, ex_sml, dexp;
    logic [MW-1:0]   m_a, m_b, m_af, m_bf;
    logic            inf_a, inf_b, nan_a, nan_b;
    logic [MW:0]     sig_a, sig_b, sig_big, sig_sml;
    logic [31:0]     dsh;
    logic [2*MW+7:0] wide;
    logic [SW-1:0]   big_ext, sml_ext, sum;
    logic [LW-1:0]   lz;
    logic            spc, spc_inv;
    logic [W-1:0]    spc_y;

    always_comb begin
        s_a   = x1[W-1];
        e_a   = x1[W-2:MW];
        m_a   = x1[MW-1:0];
        s_b   = x2[W-1] ^ sub;
        e_b   = x2[W-2:MW];
        m_b   = x2[MW-1:0];
        inf_a = (&e_a) && (m_a == '0);
        nan_a = (&e_a) && (m_a != '0);
        inf_b = (&e_b) && (m_b == '0);
        nan_b = (&e_b) && (m_b != '0);
        m_af  = (FTZ && e_a == '0) ? {MW{1'b0}} : m_a;
        m_bf  = (FTZ && e_b == '0) ? {MW{1'b0}} : m_b;
        sig_a = {e_a != '0, m_af};
        sig_b = {e_b != '0, m_bf};
        ex_a  = (e_a == '0) ? EW'(1) : e_a;
        ex_b  = (e_b == '0) ? EW'(1) : e_b;
        a_big = {ex_a, sig_a} >= {ex_b, sig_b};
        s_big   = a_big ? s_a : s_b;
        ex_big  = a_big ? ex_a : ex_b;
        ex_sml  = a_big ? ex_b : ex_a;
        sig_big = a_big ? sig_a : sig_b;
        sig_sml = a_big ? sig_b : sig_a;
        dexp    = ex_big - ex_sml;
        // Beyond MW+4 every bit of the smaller operand is already below the sticky position
        dsh     = (32'(dexp) > 32'(MW + 4)) ? 32'(MW + 4) : 32'(dexp);
        wide    = {sig_sml, 3'b000, {(MW+4){1'b0}}} >> dsh;
        sml_ext = {1'b0, wide[2*MW+7:MW+5], wide[MW+4] | (|wide[MW+3:0])};
        big_ext = {1'b0, sig_big, 3'b000};
        sum     = (s_a ^ s_b) ? big_ext - sml_ext : big_ext + sml_ext;
        lz = LW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (sum[i]) lz = LW'(SW - 1 - i);
        end
        spc     = nan_a | nan_b | inf_a | inf_b;
        spc_inv = 1'b0;
        spc_y   = {1'b1, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
        if (nan_a) begin
            spc_y = {x1[W-1:MW-1] | 1'b1, x1[MW-2:0]};
        end else if (nan_b) begin
            spc_y = {x2[W-1:MW-1] | 1'b1, x2[MW-2:0]};
        end else if (inf_a && inf_b && (s_a != s_b)) begin
            spc_inv = 1'b1;
        end else if (inf_a) begin
            spc_y = {s_a, {EW{1'b1}}, {MW{1'b0}}};
        end else if (inf_b) begin
            spc_y = {s_b, {EW{1'b1}}, {MW{1'b0}}};
        end
    end

    // Stage 2 combinational: normalise, round, pack
    logic [SW-2:0] nrm;
    logic [XW-1:0] e2, e_rnd;
    logic [31:0]   lzh, emx, shl;
    logic          rup, hid, ovf_c;
    logic [MW+1:0] rnd;
    logic [MW-1:0] m_fld;
    logic [W-1:0]  y_c;

    always_comb begin
        lzh = 32'(lz1_q) - 32'd1;
        emx = 32'(exp1_q) - 32'd1;
        // Left shift stops at emin so tiny results stay subnormal
        shl = (lzh < emx) ? lzh : emx;
        if (sum1_q[SW-1]) begin
            nrm = {sum1_q[SW-1:2], sum1_q[1] | sum1_q[0]};
            e2  = XW'(exp1_q) + XW'(1);
        end else begin
            nrm = sum1_q[SW-2:0] << shl;
            e2  = XW'(exp1_q) - XW'(shl);
        end
        rup   = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
        rnd   = {1'b0, nrm[MW+3:3]} + (MW+2)'(rup);
        e_rnd = e2 + XW'(rnd[MW+1]);
        hid   = rnd[MW+1] | rnd[MW];
        m_fld = rnd[MW-1:0];
        if (FTZ && !hid) m_fld = '0;
        ovf_c = !spc1_q && hid && (e_rnd >= XW'({EW{1'b1}}));
        if (spc1_q) begin
            y_c = spy1_q;
        end else if (ovf_c) begin
            y_c = {sgn1_q, {EW{1'b1}}, {MW{1'b0}}};
        end else begin
            y_c = {sgn1_q, hid ? e_rnd[EW-1:0] : {EW{1'b0}}, m_fld};
        end
    end

    always_comb begin
        s2_ld    = !v2_q || out_ready;
        s1_ld    = !v1_q || s2_ld;
        in_ready = s1_ld;
        v1_d   = s1_ld ? in_valid : v1_q;
        sum1_d = sum1_q;
        exp1_d = exp1_q;
        sgn1_d = sgn1_q;
        lz1_d  = lz1_q;
        spc1_d = spc1_q;
        spy1_d = spy1_q;
        inv1_d = inv1_q;
        if (s1_ld && in_valid) begin
            sum1_d = sum;
            exp1_d = ex_big;
            sgn1_d = (sum == '0 && (s_a ^ s_b)) ? 1'b0 : s_big;
            lz1_d  = lz;
            spc1_d = spc;
            spy1_d = spc_y;
            inv1_d = spc_inv;
        end
        v2_d  = s2_ld ? v1_q : v2_q;
        y_d   = y_q;
        ovf_d = ovf_q;
        inv_d = inv_q;
        if (s2_ld && v1_q) begin
            y_d   = y_c;
            ovf_d = ovf_c;
            inv_d = spc1_q & inv1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            sum1_q <= '0;
            exp1_q <= '0;
            sgn1_q <= 1'b0;
            lz1_q  <= '0;
            spc1_q <= 1'b0;
            spy1_q <= '0;
            inv1_q <= 1'b0;
            y_q    <= '0;
            ovf_q  <= 1'b0;
            inv_q  <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            sum1_q <= sum1_d;
            exp1_q <= exp1_d;
            sgn1_q <= sgn1_d;
            lz1_q  <= lz1_d;
            spc1_q <= spc1_d;
            spy1_q <= spy1_d;
            inv1_q <= inv1_d;
            y_q    <= y_d;
            ovf_q  <= ovf_d;
            inv_q  <= inv_d;
        end
    end

    assign out_valid = v2_q;
    assign y         = y_q;
    assign ovf       = ovf_q;
    assign inv       = inv_q;
endmodule

// File: tb/tb_fadd_pipe.sv
// tb/tb_fadd_pipe.sv - vector-table and flow-control bench for fadd_pipe at binary32 defaults
module tb_fadd_pipe;
    localparam int EW = 8;
    localparam int MW = 23;
    localparam int W  = 32;
`ifdef FADD_FTZ_EN
    localparam bit FTZ = 1'b1;
`else
    localparam bit FTZ = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn, in_valid, in_ready, sub, out_valid, out_ready, ovf, inv;
    logic [W-1:0] x1, x2, y;
    int           n_cmp = 0;
    int           n_bad = 0;

    fadd_pipe #(.EW(EW), .MW(MW)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .x2(x2), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .ovf(ovf), .inv(inv)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] ey;
        logic        eo;
        logic        ei;
    } vec_t;
    vec_t vt[$];

    task automatic add(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] ey, input logic eo, input logic ei);
        vec_t v;
        v.a = a; v.b = b; v.s = s; v.ey = ey; v.eo = eo; v.ei = ei;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    logic [31:0] bp_exp [4];
    logic [31:0] bp_b   [4];

    initial begin
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0; x1 = '0; x2 = '0;
        add(32'h3F800000, 32'h3F800000, 0, 32'h40000000, 0, 0);
        add(32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F800000, 1, 0);
        add(32'h3F800000, 32'h3F800000, 1, 32'h00000000, 0, 0);
        add(32'h7F800000, 32'h7F800000, 1, 32'hFFC00000, 0, 1);
        add(32'h7FA00000, 32'h3F800000, 0, 32'h7FE00000, 0, 0);
        add(32'h3F800000, 32'h33800000, 0, 32'h3F800000, 0, 0);
        add(32'h3F800000, 32'h33800001, 0, 32'h3F800001, 0, 0);
        add(32'h00000001, 32'h00000001, 0, FTZ ? 32'h00000000 : 32'h00000002, 0, 0);
        add(32'h80000000, 32'h80000000, 0, 32'h80000000, 0, 0);
        add(32'h80000000, 32'h00000000, 1, 32'h80000000, 0, 0);
        add(32'h3F800000, 32'hFF800000, 0, 32'hFF800000, 0, 0);
        add(32'h3F800000, 32'h7F800000, 1, 32'hFF800000, 0, 0);
        add(32'h7F800000, 32'h7F800000, 0, 32'h7F800000, 0, 0);
        add(32'h3F800000, 32'hFFC00001, 1, 32'hFFC00001, 0, 0);
        add(32'h40400000, 32'h3F800000, 1, 32'h40000000, 0, 0);
        add(32'h3F800000, 32'h40400000, 1, 32'hC0000000, 0, 0);
        add(32'h3F800001, 32'h33800000, 0, 32'h3F800002, 0, 0);
        add(32'h00800000, 32'h00000001, 1, FTZ ? 32'h00800000 : 32'h007FFFFF, 0, 0);
        add(32'h007FFFFF, 32'h00000001, 0, FTZ ? 32'h00000000 : 32'h00800000, 0, 0);
        add(32'h3F800000, 32'h00000001, 0, 32'h3F800000, 0, 0);
        add(32'h3FFFFFFF, 32'h33800000, 0, 32'h40000000, 0, 0);
        add(32'h3F800001, 32'h3F800000, 1, 32'h34000000, 0, 0);
        add(32'h00000003, 32'h80000001, 0, FTZ ? 32'h00000000 : 32'h00000002, 0, 0);
        add(32'hBF800000, 32'hBF800000, 0, 32'hC0000000, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.y", y, 32'd0);
        chk("rst.ovf", 32'(ovf), 32'd0);
        chk("rst.inv", 32'(inv), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        rstn = 1'b1;

        // Streamed vector table, one op per cycle, out_ready held high
        for (int j = 0; j < vt.size() + 2; j++) begin
            @(negedge clk);
            if (j >= 2) begin
                chk($sformatf("tbl%0d.valid", j - 2), 32'(out_valid), 32'd1);
                chk($sformatf("tbl%0d.y", j - 2), y, vt[j-2].ey);
                chk($sformatf("tbl%0d.ovf", j - 2), 32'(ovf), 32'(vt[j-2].eo));
                chk($sformatf("tbl%0d.inv", j - 2), 32'(inv), 32'(vt[j-2].ei));
            end else begin
                chk($sformatf("tbl.lat%0d", j), 32'(out_valid), 32'd0);
            end
            if (j < vt.size()) begin
                in_valid = 1'b1; x1 = vt[j].a; x2 = vt[j].b; sub = vt[j].s;
                #1 chk($sformatf("tbl%0d.in_ready", j), 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("tbl.drain", 32'(out_valid), 32'd0);

        // Back-pressure: four ops 1.0+n, out_ready low for cycles 1-5
        bp_b[0] = 32'h3F800000; bp_b[1] = 32'h40000000; bp_b[2] = 32'h40400000; bp_b[3] = 32'h40800000;
        bp_exp[0] = 32'h40000000; bp_exp[1] = 32'h40400000; bp_exp[2] = 32'h40800000; bp_exp[3] = 32'h40A00000;
        begin
            int k, rcv, stall_seen, first_rcv;
            logic acc;
            k = 0; rcv = 0; stall_seen = 0; first_rcv = -1;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                out_ready = !(c >= 1 && c <= 5);
                in_valid = (k < 4);
                x1 = 32'h3F800000; x2 = bp_b[k % 4]; sub = 1'b0;
                #1;
                acc = in_valid && in_ready;
                if (c >= 2 && c <= 5) begin
                    chk($sformatf("bp.stall_ready%0d", c), 32'(in_ready), 32'd0);
                    chk($sformatf("bp.hold_valid%0d", c), 32'(out_valid), 32'd1);
                    chk($sformatf("bp.hold_y%0d", c), y, bp_exp[0]);
                    stall_seen++;
                end
                if (out_valid && out_ready) begin
                    if (rcv < 4) chk($sformatf("bp.res%0d", rcv), y, bp_exp[rcv]);
                    if (rcv < 4) chk($sformatf("bp.cycle%0d", rcv), 32'(c), 32'(6 + rcv));
                    rcv++;
                end
                @(posedge clk);
                if (acc) k++;
            end
            in_valid = 1'b0;
            chk("bp.count", 32'(rcv), 32'd4);
            chk("bp.stalls", 32'(stall_seen), 32'd4);
        end

        // Reset while the pipe is full discards everything
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; x1 = 32'h3F800000; x2 = 32'h3F800000; sub = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid.full", 32'(out_valid), 32'd1);
        rstn = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("mid.out_valid", 32'(out_valid), 32'd0);
        chk("mid.y", y, 32'd0);
        rstn = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid.no_leftover", 32'(out_valid), 32'd0);
        chk("mid.in_ready", 32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
